// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
//   Shared types and helpers for the multiplexed seven-segment scan driver.
//   - bcd_t      : one BCD digit (codes 10-15 are legal inputs and are
//                  blanked by the downstream segment decoder).
//   - BLANK_CODE : code driven on bcd_out when a digit must show nothing.
//   - MAX_DIGITS : widest display the scan driver supports.
//   - onehot()   : digit index -> one-hot select vector (MAX_DIGITS wide,
//                  callers cast down to their own digit count).
// ---------------------------------------------------------------------------
package seg7_pkg;

  localparam int MAX_DIGITS = 8;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BLANK_CODE = 4'hF;

  // Returns a vector with only bit 'idx' set.
  function automatic logic [MAX_DIGITS-1:0] onehot(input logic [2:0] idx);
    logic [MAX_DIGITS-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage : seg7_pkg

// File: rtl/seg7_prescaler.sv
// ---------------------------------------------------------------------------
// seg7_prescaler
//   Free-running slot timer for the scan driver. Counts 0..DIV-1 and raises
//   tc for the single cycle in which the count sits at DIV-1, so one slot is
//   exactly DIV clocks long.
//
// Parameters
//   DIV  clocks per digit slot (>= 2)
//
// Ports
//   clk  in   single clock
//   rst  in   synchronous, active-high reset (count returns to 0)
//   tc   out  terminal-count strobe, high while count == DIV-1
// ---------------------------------------------------------------------------
module seg7_prescaler #(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic tc
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt;

  // tc is decoded from the registered count, so it is a clean one-cycle
  // strobe that the top level samples on the edge that ends the slot.
  assign tc = (cnt == CNT_W'(DIV - 1));

  // Count up and wrap to zero on terminal count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (tc) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule : seg7_prescaler

// File: rtl/seg7_scan.sv
// ---------------------------------------------------------------------------
// seg7_scan
//   Multiplexed scan driver for a DIGITS-digit seven-segment display.
//   Cycles through the stored digits one slot (DIV clocks) at a time and
//   presents the selected digit's BCD code, decimal point and one-hot
//   enable. New data is staged in a pending register and only committed
//   when the scan wraps from the last digit back to digit 0, so a single
//   frame never mixes old and new values.
//
// Parameters
//   DIGITS  number of digits scanned (2..8)
//   DIV     clocks per digit slot (>= 2)
//
// Ports
//   clk      in   single clock
//   rst      in   synchronous, active-high reset
//   load     in   capture din/dp_in into the pending register this cycle
//   din      in   BCD digits, din[3:0] is digit 0 (rightmost)
//   dp_in    in   decimal-point flags, bit i belongs to digit i
//   bcd_out  out  BCD code of the selected digit (to the segment decoder)
//   dp_out   out  decimal point of the selected digit
//   sel      out  one-hot digit enable, active high
//   frame    out  one-cycle pulse in the first cycle of each new frame
//
// Build options
//   LZ_BLANK_EN  when defined, leading zeros (from the top digit down, never
//                digit 0) are shown as BLANK_CODE with the decimal point off.
// ---------------------------------------------------------------------------
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int DIV    = 50000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [4*DIGITS-1:0] din,
  input  logic [DIGITS-1:0]   dp_in,
  output logic [3:0]          bcd_out,
  output logic                dp_out,
  output logic [DIGITS-1:0]   sel,
  output logic                frame
);

  localparam int IDX_W = $clog2(DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  logic                tc;
  logic                wrap;
  logic                wrap_d;
  logic [IDX_W-1:0]    idx;

  logic [4*DIGITS-1:0] disp_digits;
  logic [DIGITS-1:0]   disp_dp;
  logic [4*DIGITS-1:0] pend_digits;
  logic [DIGITS-1:0]   pend_dp;
  logic                pend_vld;

  logic [DIGITS-1:0]   blank;
  bcd_t                cur_bcd;
  logic                cur_dp;
  logic [DIGITS-1:0]   cur_sel;

  seg7_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .tc  (tc)
  );

  // The wrap slot is the last cycle of the last digit: the frame boundary
  // where pending data may be committed.
  assign wrap = tc && (idx == LAST_IDX);

  // Digit index: advances once per slot, wrapping back to digit 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
    end else if (tc) begin
      if (idx == LAST_IDX) begin
        idx <= '0;
      end else begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

  // Display and pending registers. A load on the wrap cycle bypasses the
  // pending stage entirely, so whatever was pending before is dropped;
  // otherwise a pending value is committed at the wrap and a load simply
  // overwrites pending (last load wins).
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_digits <= '0;
      disp_dp     <= '0;
      pend_digits <= '0;
      pend_dp     <= '0;
      pend_vld    <= 1'b0;
    end else if (wrap && load) begin
      disp_digits <= din;
      disp_dp     <= dp_in;
      pend_vld    <= 1'b0;
    end else begin
      if (wrap && pend_vld) begin
        disp_digits <= pend_digits;
        disp_dp     <= pend_dp;
        pend_vld    <= 1'b0;
      end
      if (load) begin
        pend_digits <= din;
        pend_dp     <= dp_in;
        pend_vld    <= 1'b1;
      end
    end
  end

  // Leading-zero mask, derived from the committed display only. Walking
  // down from the top digit, a digit is blanked while it and everything
  // above it are zero; digit 0 always shows.
`ifdef LZ_BLANK_EN
  always_comb begin
    logic zero_above;
    blank      = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above && (disp_digits[4*i +: 4] == 4'h0);
      blank[i]   = zero_above;
    end
  end
`else
  always_comb begin
    blank = '0;
  end
`endif

  // Select the current digit and apply blanking.
  always_comb begin
    cur_sel = DIGITS'(onehot(3'(idx)));
    cur_bcd = disp_digits[4*idx +: 4];
    cur_dp  = disp_dp[idx];
    if (blank[idx]) begin
      cur_bcd = BLANK_CODE;
      cur_dp  = 1'b0;
    end
  end

  // Output registers. They sample the current index, so outputs trail the
  // index by one clock; this keeps every slot, including the first one
  // after reset, exactly DIV cycles long. wrap_d delays the wrap strobe so
  // frame lines up with the first cycle that shows digit 0 of the new frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel     <= '0;
      bcd_out <= BLANK_CODE;
      dp_out  <= 1'b0;
      frame   <= 1'b0;
      wrap_d  <= 1'b0;
    end else begin
      sel     <= cur_sel;
      bcd_out <= cur_bcd;
      dp_out  <= cur_dp;
      frame   <= wrap_d;
      wrap_d  <= wrap;
    end
  end

endmodule : seg7_scan

// File: tb/tb_seg7_scan.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan
//   Self-checking bench for seg7_scan with DIGITS=4, DIV=4 (16-cycle frame).
//   Expected outputs come from a frame-level model: the bench counts clock
//   edges since reset release, knows which slot and frame each cycle belongs
//   to, and tracks which rendered digits each frame must show. Each
//   vector carries its own hand-written rendered digits (blanking applied
//   for LZ_BLANK_EN builds).
// ---------------------------------------------------------------------------
module tb_seg7_scan;

  localparam int DIGITS = 4;
  localparam int DIV    = 4;
  localparam int FRAME  = DIGITS * DIV;

  typedef struct packed {
    logic [3:0] sel;
    logic [3:0] bcd;
    logic       dp;
    logic       frame;
  } obs_t;

  typedef struct {
    logic [15:0] din;
    logic [3:0]  dp;
    logic [15:0] exp_bcd;
    logic [3:0]  exp_dp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] din;
  logic [3:0]  dp_in;
  logic [3:0]  bcd_out;
  logic        dp_out;
  logic [3:0]  sel;
  logic        frame;

  int tests_run    = 0;
  int tests_failed = 0;

  // Frame-level model state.
  int          n;
  logic [15:0] cur_b;
  logic [3:0]  cur_d;
  logic [15:0] next_b;
  logic [3:0]  next_d;
  bit          have_next;
  logic [15:0] reset_b;

  obs_t sb[$];
  vec_t vecs[6];

  seg7_scan #(
    .DIGITS (DIGITS),
    .DIV    (DIV)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .din     (din),
    .dp_in   (dp_in),
    .bcd_out (bcd_out),
    .dp_out  (dp_out),
    .sel     (sel),
    .frame   (frame)
  );

  // 10-time-unit clock.
  always #5 clk = ~clk;

  // One field comparison.
  task automatic cmp(input string tag, input string field,
                     input logic [3:0] act, input logic [3:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s.%s edge %0d: got %h, expected %h", tag, field, n, act, exp);
    end
  endtask

  // Pop the expected observation for this cycle and compare all outputs.
  task automatic checkOutput(input string tag);
    obs_t e;
    if (sb.size() == 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL %s.scoreboard: got empty queue, expected an entry", tag);
      return;
    end
    e = sb.pop_front();
    cmp(tag, "sel",   sel,            e.sel);
    cmp(tag, "bcd",   bcd_out,        e.bcd);
    cmp(tag, "dp",    {3'b0, dp_out}, {3'b0, e.dp});
    cmp(tag, "frame", {3'b0, frame},  {3'b0, e.frame});
  endtask

  // Drive one cycle of inputs, push what the outputs must be after the
  // coming edge, then check them on the following falling edge.
  task automatic applyStimulus(input bit r, input bit ld,
                               input logic [15:0] d, input logic [3:0] p,
                               input logic [15:0] eb, input logic [3:0] ed,
                               input string tag);
    obs_t e;
    int   slot;
    rst   = r;
    load  = ld;
    din   = d;
    dp_in = p;
    if (r) begin
      n         = 0;
      cur_b     = reset_b;
      cur_d     = 4'b0000;
      have_next = 1'b0;
      e         = '{sel: 4'b0000, bcd: 4'hF, dp: 1'b0, frame: 1'b0};
    end else begin
      n++;
      // Loads sampled in edges (16(k-1), 16k] belong to frame k.
      if (n > 1 && ((n - 1) % FRAME) == 0 && have_next) begin
        cur_b     = next_b;
        cur_d     = next_d;
        have_next = 1'b0;
      end
      if (ld) begin
        next_b    = eb;
        next_d    = ed;
        have_next = 1'b1;
      end
      slot    = ((n - 1) / DIV) % DIGITS;
      e.sel   = 4'b0001 << slot;
      e.bcd   = cur_b[4*slot +: 4];
      e.dp    = cur_d[slot];
      e.frame = (n > 1) && (((n - 1) % FRAME) == 0);
    end
    sb.push_back(e);
    @(negedge clk);
    checkOutput(tag);
  endtask

  task automatic idle(input int cycles, input string tag);
    for (int i = 0; i < cycles; i++) begin
      applyStimulus(1'b0, 1'b0, 16'h0, 4'h0, 16'h0, 4'h0, tag);
    end
  endtask

  // Idle until the next edge will be the one at frame phase 'phase'
  // (phase 0 = edge that shows digit 0, phase 15 = wrap edge).
  task automatic idleUntil(input int phase, input string tag);
    for (int i = 0; i < FRAME && (n % FRAME) != phase; i++) begin
      applyStimulus(1'b0, 1'b0, 16'h0, 4'h0, 16'h0, 4'h0, tag);
    end
  endtask

  task automatic loadVal(input logic [15:0] d, input logic [3:0] p,
                         input logic [15:0] eb, input logic [3:0] ed,
                         input string tag);
    applyStimulus(1'b0, 1'b1, d, p, eb, ed, tag);
  endtask

  // Test sequence.
  initial begin
`ifdef LZ_BLANK_EN
    reset_b = 16'hFFF0;
    vecs[0] = '{16'h1234, 4'b0100, 16'h1234, 4'b0100};
    vecs[1] = '{16'h0050, 4'b1111, 16'hFF50, 4'b0011};
    vecs[2] = '{16'h0000, 4'b0001, 16'hFFF0, 4'b0001};
    vecs[3] = '{16'hABCD, 4'b1010, 16'hABCD, 4'b1010};
    vecs[4] = '{16'hFA0C, 4'b0000, 16'hFA0C, 4'b0000};
    vecs[5] = '{16'h0007, 4'b1000, 16'hFFF7, 4'b0000};
`else
    reset_b = 16'h0000;
    vecs[0] = '{16'h1234, 4'b0100, 16'h1234, 4'b0100};
    vecs[1] = '{16'h0050, 4'b1111, 16'h0050, 4'b1111};
    vecs[2] = '{16'h0000, 4'b0001, 16'h0000, 4'b0001};
    vecs[3] = '{16'hABCD, 4'b1010, 16'hABCD, 4'b1010};
    vecs[4] = '{16'hFA0C, 4'b0000, 16'hFA0C, 4'b0000};
    vecs[5] = '{16'h0007, 4'b1000, 16'h0007, 4'b1000};
`endif
    n         = 0;
    cur_b     = reset_b;
    cur_d     = 4'b0000;
    next_b    = 16'h0;
    next_d    = 4'h0;
    have_next = 1'b0;
    rst       = 1'b1;
    load      = 1'b0;
    din       = 16'h0;
    dp_in     = 4'h0;
    @(negedge clk);

    // Reset held three cycles, then release and scan the zero display.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 16'h0, 4'h0, 16'h0, 4'h0, "reset");
    end
    idle(FRAME + 4, "release");

    // Table of values, each loaded at a different frame phase.
    for (int i = 0; i < 6; i++) begin
      idleUntil((i * 3) % FRAME, "vec_align");
      loadVal(vecs[i].din, vecs[i].dp, vecs[i].exp_bcd, vecs[i].exp_dp, "vec_load");
      idle(2 * FRAME, "vec_scan");
    end

    // Tear-free update: new value loaded while digit 2 is shown.
    idleUntil(2, "tear_align");
    loadVal(16'h1234, 4'b0100, 16'h1234, 4'b0100, "tear_base");
    idle(FRAME + 2, "tear_run");
    idleUntil(9, "tear_align2");
    loadVal(16'h5678, 4'b0000, 16'h5678, 4'b0000, "tear_load");
    idle(2 * FRAME, "tear_scan");

    // Two loads in one frame: last one wins.
    idleUntil(1, "ovr_align");
    loadVal(16'h1111, 4'b0001, 16'h1111, 4'b0001, "ovr_first");
    idleUntil(7, "ovr_align2");
    loadVal(16'h2222, 4'b0010, 16'h2222, 4'b0010, "ovr_second");
    idle(2 * FRAME, "ovr_scan");

    // Load on the wrap cycle with an older value pending: the older value
    // must never appear, and the following frame keeps showing 9s.
    idleUntil(3, "col_align");
    loadVal(16'h1111, 4'b1111, 16'h1111, 4'b1111, "col_pending");
    idleUntil(15, "col_align2");
    loadVal(16'h9999, 4'b0000, 16'h9999, 4'b0000, "col_load");
    idle(2 * FRAME, "col_scan");

    // Reset while digit 1 is shown and a load is pending.
    idleUntil(1, "rstmid_align");
    loadVal(16'h7777, 4'b1111, 16'h7777, 4'b1111, "rstmid_load");
    idleUntil(5, "rstmid_align2");
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b0, 16'h0, 4'h0, 16'h0, 4'h0, "rstmid_reset");
    end
    idle(2 * FRAME + 4, "rstmid_scan");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_seg7_scan
